// File: rtl/fp_reg_file_sb.sv
// Register file for the FP datapath: two registered read ports, one (optionally paired) write port,
// and a per-entry busy scoreboard that gates operand reads until pending producers write back.
module fp_reg_file_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  localparam int unsigned DEPTH = 1 << ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd1_ad,
  input  logic [ADDR_W-1:0] rd2_ad,
  output logic [DATA_W-1:0] rd1_val,
  output logic [DATA_W-1:0] rd2_val,
  output logic              rd_vld,
  input  logic              wr_en,
  input  logic              wr_pair,
  input  logic [ADDR_W-1:0] wr_ad,
  input  logic [DATA_W-1:0] wr_val,
  input  logic [DATA_W-1:0] wr_val2,
  input  logic              rsv_en,
  input  logic              rsv_pair,
  input  logic [ADDR_W-1:0] rsv_ad,
  output logic [DEPTH-1:0]  busy
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ad2;
  logic [ADDR_W-1:0] rsv_ad2;
  logic [DEPTH-1:0]  wr_mask;
  logic [DEPTH-1:0]  rsv_mask;
  logic [DEPTH-1:0]  busy_eff;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DATA_W-1:0] rd1_byp;
  logic [DATA_W-1:0] rd2_byp;
  logic              issue;

  // Pair addresses wrap modulo DEPTH through natural ADDR_W-bit overflow.
  assign wr_ad2  = wr_ad + ADDR_W'(1);
  assign rsv_ad2 = rsv_ad + ADDR_W'(1);

  always_comb begin
    wr_mask  = '0;
    rsv_mask = '0;
    if (wr_en) begin
      wr_mask[wr_ad] = 1'b1;
      if (wr_pair) wr_mask[wr_ad2] = 1'b1;
    end
    if (rsv_en) begin
      rsv_mask[rsv_ad] = 1'b1;
      if (rsv_pair) rsv_mask[rsv_ad2] = 1'b1;
    end
  end

  // Releases apply before the issue check; reservations apply after, so a new owner wins a collision.
  assign busy_eff = busy & ~wr_mask;
  assign busy_nxt = busy_eff | rsv_mask;

  // Write-first bypass: same-cycle write data overrides the stored value.
  always_comb begin
    rd1_byp = mem[rd1_ad];
    rd2_byp = mem[rd2_ad];
    if (wr_en && wr_pair && (rd1_ad == wr_ad2)) rd1_byp = wr_val2;
    if (wr_en && wr_pair && (rd2_ad == wr_ad2)) rd2_byp = wr_val2;
    if (wr_en && (rd1_ad == wr_ad)) rd1_byp = wr_val;
    if (wr_en && (rd2_ad == wr_ad)) rd2_byp = wr_val;
  end

  assign issue = rd_en && !busy_eff[rd1_ad] && !busy_eff[rd2_ad];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd1_val <= '0;
      rd2_val <= '0;
      rd_vld  <= 1'b0;
      busy    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      busy   <= busy_nxt;
      rd_vld <= issue;
      if (issue) begin
        rd1_val <= rd1_byp;
        rd2_val <= rd2_byp;
      end
      if (wr_en) mem[wr_ad] <= wr_val;
      if (wr_en && wr_pair) mem[wr_ad2] <= wr_val2;
    end
  end

endmodule

// File: tb/tb_fp_reg_file_sb.sv
// Self-checking bench for fp_reg_file_sb: directed vector table with hand-computed expectations,
// then a random phase checked against a behavioural model through an expectation queue.
module tb_fp_reg_file_sb;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        rd_en;
  logic [3:0]  rd1_ad, rd2_ad;
  logic [31:0] rd1_val, rd2_val;
  logic        rd_vld;
  logic        wr_en, wr_pair;
  logic [3:0]  wr_ad;
  logic [31:0] wr_val, wr_val2;
  logic        rsv_en, rsv_pair;
  logic [3:0]  rsv_ad;
  logic [15:0] busy;

  fp_reg_file_sb #(.DATA_W(32), .ADDR_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .rd_en(rd_en), .rd1_ad(rd1_ad), .rd2_ad(rd2_ad),
    .rd1_val(rd1_val), .rd2_val(rd2_val), .rd_vld(rd_vld), .wr_en(wr_en), .wr_pair(wr_pair),
    .wr_ad(wr_ad), .wr_val(wr_val), .wr_val2(wr_val2), .rsv_en(rsv_en), .rsv_pair(rsv_pair),
    .rsv_ad(rsv_ad), .busy(busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic        rst, rd_en;
    logic [3:0]  r1, r2;
    logic        we, wp;
    logic [3:0]  wa;
    logic [31:0] wv, wv2;
    logic        re, rp;
    logic [3:0]  ra;
    logic        e_vld;
    logic [31:0] e1, e2;
    logic [15:0] e_busy;
  } vec_t;

  typedef struct {
    string       name;
    logic        vld;
    logic [31:0] v1, v2;
    logic [15:0] busy;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // Behavioural model state for the random phase.
  logic [31:0] m_mem [16];
  logic [15:0] m_busy;
  logic [31:0] m_r1, m_r2;
  logic        m_vld;

  function automatic vec_t mk(string n, logic rst, logic re_, logic [3:0] r1, logic [3:0] r2,
                              logic we, logic wp, logic [3:0] wa, logic [31:0] wv, logic [31:0] wv2,
                              logic sv, logic sp, logic [3:0] sa,
                              logic ev, logic [31:0] e1, logic [31:0] e2, logic [15:0] eb);
    vec_t v;
    v.name = n; v.rst = rst; v.rd_en = re_; v.r1 = r1; v.r2 = r2;
    v.we = we; v.wp = wp; v.wa = wa; v.wv = wv; v.wv2 = wv2;
    v.re = sv; v.rp = sp; v.ra = sa;
    v.e_vld = ev; v.e1 = e1; v.e2 = e2; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", n, act, req);
  endtask

  task automatic drive(vec_t v);
    Reset = v.rst; rd_en = v.rd_en; rd1_ad = v.r1; rd2_ad = v.r2;
    wr_en = v.we; wr_pair = v.wp; wr_ad = v.wa; wr_val = v.wv; wr_val2 = v.wv2;
    rsv_en = v.re; rsv_pair = v.rp; rsv_ad = v.ra;
  endtask

  // Pop the oldest expectation and compare it with the outputs one edge after its stimulus.
  task automatic tick_and_check();
    exp_t e;
    @(posedge Clock);
    #1;
    if (q.size() == 0) begin
      total_cnt++;
      $display("FAIL scoreboard: no expectation queued, got vld=%b", rd_vld);
    end else begin
      e = q.pop_front();
      chk({e.name, ".rd_vld"}, 32'(rd_vld), 32'(e.vld));
      chk({e.name, ".rd1_val"}, rd1_val, e.v1);
      chk({e.name, ".rd2_val"}, rd2_val, e.v2);
      chk({e.name, ".busy"}, 32'(busy), 32'(e.busy));
    end
  endtask

  function automatic logic [31:0] model_rd(logic [3:0] a, vec_t v);
    logic [3:0] a2;
    a2 = v.wa + 4'd1;
    if (v.we && a == v.wa) return v.wv;
    if (v.we && v.wp && a == a2) return v.wv2;
    return m_mem[a];
  endfunction

  function automatic exp_t model_step(vec_t v);
    exp_t        e;
    logic [15:0] wm, rm, beff;
    logic [3:0]  wa2, ra2;
    logic        iss;
    wa2 = v.wa + 4'd1;
    ra2 = v.ra + 4'd1;
    wm = '0; rm = '0;
    if (v.we) begin wm[v.wa] = 1'b1; if (v.wp) wm[wa2] = 1'b1; end
    if (v.re) begin rm[v.ra] = 1'b1; if (v.rp) rm[ra2] = 1'b1; end
    beff = m_busy & ~wm;
    iss = v.rd_en && !beff[v.r1] && !beff[v.r2];
    if (iss) begin m_r1 = model_rd(v.r1, v); m_r2 = model_rd(v.r2, v); end
    m_vld = iss;
    if (v.we) m_mem[v.wa] = v.wv;
    if (v.we && v.wp) m_mem[wa2] = v.wv2;
    m_busy = beff | rm;
    e.name = "rand"; e.vld = m_vld; e.v1 = m_r1; e.v2 = m_r2; e.busy = m_busy;
    return e;
  endfunction

  vec_t tbl[20];

  initial begin
    vec_t v;
    exp_t e;
    //               name          rst re r1 r2  we wp wa  wv            wv2           sv sp sa  ev e1            e2            busy
    tbl[0]  = mk("reset",        1, 0, 0, 0,  0, 0, 0,  32'h0,        32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        16'h0000);
    tbl[1]  = mk("preload_pair", 0, 0, 0, 0,  1, 1, 14, 32'h11111111, 32'h22222222, 0, 0, 0,  0, 32'h0,        32'h0,        16'h0000);
    tbl[2]  = mk("preload_rd",   0, 1, 14, 2, 1, 0, 2,  32'h33333333, 32'h0,        0, 0, 0,  1, 32'h11111111, 32'h33333333, 16'h0000);
    tbl[3]  = mk("reset2",       1, 0, 0, 0,  0, 0, 0,  32'h0,        32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        16'h0000);
    tbl[4]  = mk("post_rst_rd",  0, 1, 2, 15, 1, 0, 14, 32'hAAAA5555, 32'h0,        0, 0, 0,  1, 32'h0,        32'h0,        16'h0000);
    tbl[5]  = mk("wrap_write",   0, 0, 0, 0,  1, 1, 15, 32'h3F800000, 32'h40000000, 0, 0, 0,  0, 32'h0,        32'h0,        16'h0000);
    tbl[6]  = mk("wrap_read",    0, 1, 15, 0, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0,  1, 32'h3F800000, 32'h40000000, 16'h0000);
    tbl[7]  = mk("entry14_kept", 0, 1, 14, 14,0, 0, 0,  32'h0,        32'h0,        0, 0, 0,  1, 32'hAAAA5555, 32'hAAAA5555, 16'h0000);
    tbl[8]  = mk("bypass",       0, 1, 5, 0,  1, 0, 5,  32'hC0490FDB, 32'h0,        0, 0, 0,  1, 32'hC0490FDB, 32'h40000000, 16'h0000);
    tbl[9]  = mk("reserve_pair", 0, 0, 0, 0,  0, 0, 0,  32'h0,        32'h0,        1, 1, 3,  0, 32'hC0490FDB, 32'h40000000, 16'h0018);
    tbl[10] = mk("stall",        0, 1, 5, 4,  0, 0, 0,  32'h0,        32'h0,        0, 0, 0,  0, 32'hC0490FDB, 32'h40000000, 16'h0018);
    tbl[11] = mk("release_rd",   0, 1, 5, 4,  1, 1, 3,  32'h12345678, 32'h9ABCDEF0, 0, 0, 0,  1, 32'hC0490FDB, 32'h9ABCDEF0, 16'h0000);
    tbl[12] = mk("collide",      0, 1, 7, 3,  1, 0, 7,  32'h7777AAAA, 32'h0,        1, 0, 7,  1, 32'h7777AAAA, 32'h12345678, 16'h0080);
    tbl[13] = mk("collide_hold", 0, 1, 7, 3,  0, 0, 0,  32'h0,        32'h0,        0, 0, 0,  0, 32'h7777AAAA, 32'h12345678, 16'h0080);
    tbl[14] = mk("release7",     0, 1, 7, 15, 1, 0, 7,  32'h0BADF00D, 32'h0,        0, 0, 0,  1, 32'h0BADF00D, 32'h3F800000, 16'h0000);
    tbl[15] = mk("rsv_wrap",     0, 1, 0, 1,  0, 0, 0,  32'h0,        32'h0,        1, 1, 15, 1, 32'h40000000, 32'h0,        16'h8001);
    tbl[16] = mk("rsv_wrap_stl", 0, 1, 1, 0,  0, 0, 0,  32'h0,        32'h0,        0, 0, 0,  0, 32'h40000000, 32'h0,        16'h8001);
    tbl[17] = mk("rst_midstrm",  1, 1, 2, 5,  1, 0, 2,  32'hDEADBEEF, 32'h0,        1, 0, 9,  0, 32'h0,        32'h0,        16'h0000);
    tbl[18] = mk("after_rst_rd", 0, 1, 2, 15, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0,  1, 32'h0,        32'h0,        16'h0000);
    tbl[19] = mk("pair_bypass",  0, 1, 0, 15, 1, 1, 15, 32'h00000001, 32'h00000002, 0, 0, 0,  1, 32'h00000002, 32'h00000001, 16'h0000);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i]);
      e.name = tbl[i].name; e.vld = tbl[i].e_vld; e.v1 = tbl[i].e1; e.v2 = tbl[i].e2; e.busy = tbl[i].e_busy;
      q.push_back(e);
      tick_and_check();
    end

    // Random phase starts from a known reset state.
    v = mk("rand_rst", 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 16'h0);
    drive(v);
    e.name = "rand_rst"; e.vld = 1'b0; e.v1 = '0; e.v2 = '0; e.busy = '0;
    q.push_back(e);
    tick_and_check();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_busy = '0; m_r1 = '0; m_r2 = '0; m_vld = 1'b0;

    for (int i = 0; i < 200; i++) begin
      v = mk("rand", 0, 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 4'($urandom),
             0, 32'h0, 32'h0, 16'h0);
      drive(v);
      q.push_back(model_step(v));
      tick_and_check();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
